shotclock_ctrl: RTL

SHOTCLOCK_CTRL -- requirements
Module: shotclock_ctrl

---
 rtl/shotclock_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/shotclock_ctrl.sv
// ============================================================================
// shotclock_ctrl -- shot-clock control FSM: reloads, run/pause, expiry horn.
// Optional macro SHOTCLOCK_FLASH_EN: blink the display while expired.
// Revision: 1.0
// ============================================================================
`default_nettype none

module shotclock_ctrl #(
    parameter logic [7:0] FULL_BCD    = 8'h24,
    parameter logic [7:0] SHORT_BCD   = 8'h14,
    parameter int         BUZZ_CYCLES = 50_000_000
) (
    input  logic       CLK100MHZ,
    input  logic       rst,
    input  logic       start_pulse,
    input  logic       stop_pulse,
    input  logic       reset24_pulse,
    input  logic       reset14_pulse,
    input  logic       tick_1hz,
    input  logic       zero,
    output logic       load,
    output logic [7:0] load_bcd,
    output logic       tick_out,
    output logic       buzzer,
    output logic       blank,
    output logic [2:0] state
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_READY   = 3'd1;
    localparam logic [2:0] c_RUN     = 3'd2;
    localparam logic [2:0] c_PAUSE   = 3'd3;
    localparam logic [2:0] c_EXPIRED = 3'd4;

    localparam logic [2:0] c_CMD_NONE  = 3'd0;
    localparam logic [2:0] c_CMD_R24   = 3'd1;
    localparam logic [2:0] c_CMD_R14   = 3'd2;
    localparam logic [2:0] c_CMD_STOP  = 3'd3;
    localparam logic [2:0] c_CMD_START = 3'd4;

    localparam int                 c_CNT_W     = $clog2(BUZZ_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_BUZZ_LAST = c_CNT_W'(BUZZ_CYCLES - 1);

    logic [2:0]         state_q, state_d;
    logic               load_q, load_d;
    logic [7:0]         load_bcd_q, load_bcd_d;
    logic               buzzer_q, buzzer_d;
    logic               blank_q, blank_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]         w_cmd;
    logic               w_reload;
    logic               w_enter_exp;

    // State register
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state_q    <= c_IDLE;
            load_q     <= 1'b0;
            load_bcd_q <= FULL_BCD;
            buzzer_q   <= 1'b0;
            blank_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            load_q     <= load_d;
            load_bcd_q <= load_bcd_d;
            buzzer_q   <= buzzer_d;
            blank_q    <= blank_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state logic; only the highest-priority pulse of a cycle is seen
    always_comb begin
        w_cmd = c_CMD_NONE;
        if (reset24_pulse)      w_cmd = c_CMD_R24;
        else if (reset14_pulse) w_cmd = c_CMD_R14;
        else if (stop_pulse)    w_cmd = c_CMD_STOP;
        else if (start_pulse)   w_cmd = c_CMD_START;

        w_reload = (state_q != c_IDLE) && ((w_cmd == c_CMD_R24) || (w_cmd == c_CMD_R14));

        state_d = state_q;
        case (state_q)
            c_IDLE:    state_d = c_READY;
            c_READY:   if (w_cmd == c_CMD_START) state_d = c_RUN;
            c_RUN: begin
                // zero lags a load by one cycle, so it is untrusted while load is high
                if (w_cmd == c_CMD_STOP)        state_d = c_PAUSE;
                else if (!w_reload && zero && !load_q) state_d = c_EXPIRED;
            end
            c_PAUSE:   if (w_cmd == c_CMD_START) state_d = c_RUN;
            c_EXPIRED: if (w_reload) state_d = c_READY;
            default:   state_d = c_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        load_d     = (state_q == c_IDLE) || w_reload;
        load_bcd_d = load_bcd_q;
        if ((state_q == c_IDLE) || (w_reload && (w_cmd == c_CMD_R24)))
            load_bcd_d = FULL_BCD;
        else if (w_reload)
            load_bcd_d = SHORT_BCD;

        w_enter_exp = (state_q != c_EXPIRED) && (state_d == c_EXPIRED);

        buzzer_d = buzzer_q;
        cnt_d    = cnt_q;
        if (w_enter_exp) begin
            buzzer_d = 1'b1;
            cnt_d    = '0;
        end else if (state_d != c_EXPIRED) begin
            buzzer_d = 1'b0;
            cnt_d    = '0;
        end else if (buzzer_q) begin
            if (cnt_q == c_BUZZ_LAST) buzzer_d = 1'b0;
            else                      cnt_d    = cnt_q + c_CNT_W'(1);
        end

`ifdef SHOTCLOCK_FLASH_EN
        blank_d = blank_q;
        if (w_enter_exp || (state_d != c_EXPIRED))
            blank_d = 1'b0;
        else if (tick_1hz)
            blank_d = ~blank_q;
`else
        blank_d = 1'b0;
`endif

        tick_out = tick_1hz && (state_q == c_RUN) && !load_q;
    end

    assign load     = load_q;
    assign load_bcd = load_bcd_q;
    assign buzzer   = buzzer_q;
    assign blank    = blank_q;
    assign state    = state_q;

endmodule

`default_nettype wire
